m_seq_sync: RTL and testbench

//  Receive-side sync checker for the m-sequence alignment stream. Consumes the serial
//  m_align bit stream one bit per qualified cycle and self-seeds a local LFSR from the

---
 rtl/m_seq_pkg.sv | 22 ++
 rtl/m_seq_sync_if.sv | 23 ++
 rtl/m_lfsr.sv | 38 +++
 rtl/m_seq_sync.sv | 184 ++++++++++++++++++
 tb/tb_m_seq_sync.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_seq_pkg.sv
// Shared definitions for the m-sequence generator and sync checker:
// state encoding, default LFSR shape and the LFSR step function.
package m_seq_pkg;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;

    localparam int                   DEF_WIDTH = 3;
    localparam logic [DEF_WIDTH-1:0] DEF_TAPS  = 3'b101;

    // Widest LFSR the step function handles; callers zero-extend and truncate.
    localparam int LFSR_MAX_W = 32;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] st,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return {st[LFSR_MAX_W-2:0], ^(st & taps)};
    endfunction

endpackage

// File: rtl/m_seq_sync_if.sv
// Bit-stream input and status outputs of the m-sequence sync checker.
interface m_seq_sync_if;

    logic        din;
    logic        din_valid;
    logic        locked;
    logic [1:0]  state;
    logic        exp_bit;
    logic        bit_err;
    logic        lock_lost;
    logic [15:0] err_cnt;

    modport master (
        output din, din_valid,
        input  locked, state, exp_bit, bit_err, lock_lost, err_cnt
    );

    modport slave (
        input  din, din_valid,
        output locked, state, exp_bit, bit_err, lock_lost, err_cnt
    );

endinterface

// File: rtl/m_lfsr.sv
// Fibonacci LFSR with parallel load; advances one step per asserted advance.
module m_lfsr
    import m_seq_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             advance,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (advance) begin
            state_d = WIDTH'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/m_seq_sync.sv
// Receive-side m-sequence sync checker: self-seeds a local LFSR from the
// incoming bits, verifies it, holds lock and drops it on excessive errors.
module m_seq_sync
    import m_seq_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEF_TAPS),
    parameter int               VERIFY_LEN = 7,
    parameter int               WIN_LEN    = 16,
    parameter int               LOSS_THR   = 3
) (
    input logic         clk,
    input logic         rst,
    m_seq_sync_if.slave bus
);

    localparam int HC_W = $clog2(WIDTH + 1);
    localparam int VC_W = $clog2(VERIFY_LEN + 1);
    localparam int WC_W = $clog2(WIN_LEN + 1);
    localparam int EC_W = $clog2(LOSS_THR + 1);

    localparam logic [HC_W-1:0] HC_SAT  = HC_W'(WIDTH);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(WIDTH - 1);
    localparam logic [VC_W-1:0] VC_LAST = VC_W'(VERIFY_LEN - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WIN_LEN - 1);
    localparam logic [EC_W-1:0] EC_LAST = EC_W'(LOSS_THR - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [HC_W-1:0]  hcnt_q, hcnt_d;
    logic [VC_W-1:0]  vcnt_q, vcnt_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic [EC_W-1:0]  werr_q, werr_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             exp_bit_q, exp_bit_d;
    logic             bit_err_q, bit_err_d;
    logic             lock_lost_q, lock_lost_d;

    logic             gen_load;
    logic             gen_adv;
    logic [WIDTH-1:0] gen_w;
    logic [WIDTH-1:0] sh_new;
    logic             exp_w;
    logic             mismatch;
    logic             hunt_ready;

    m_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (gen_load),
        .load_val (sh_new),
        .advance  (gen_adv),
        .state    (gen_w)
    );

    // sh holds the transmitter state: oldest received bit in the MSB.
    assign sh_new     = WIDTH'({sh_q, bus.din});
    assign exp_w      = ^(gen_w & TAPS);
    assign mismatch   = (exp_w != bus.din);
    assign hunt_ready = (hcnt_q >= HC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (hunt_ready && (sh_new != '0)) state_d = ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (mismatch)                state_d = ST_HUNT;
                    else if (vcnt_q == VC_LAST)  state_d = ST_LOCK;
                end
                ST_LOCK: begin
                    if (mismatch && (werr_q == EC_LAST)) state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        sh_d        = sh_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        wcnt_d      = wcnt_q;
        werr_d      = werr_q;
        err_cnt_d   = err_cnt_q;
        exp_bit_d   = exp_bit_q;
        bit_err_d   = 1'b0;
        lock_lost_d = 1'b0;
        gen_load    = 1'b0;
        gen_adv     = 1'b0;
        if (bus.din_valid) begin
            sh_d      = sh_new;
            exp_bit_d = 1'b0;
            case (state_q)
                ST_HUNT: begin
                    if (hcnt_q != HC_SAT) hcnt_d = hcnt_q + HC_W'(1);
                    if (state_d == ST_VERIFY) begin
                        gen_load = 1'b1;
                        vcnt_d   = '0;
                    end
                end
                ST_VERIFY: begin
                    gen_adv   = 1'b1;
                    exp_bit_d = exp_w;
                    if (mismatch) begin
                        bit_err_d = 1'b1;
                        hcnt_d    = '0;
                    end else begin
                        vcnt_d = vcnt_q + VC_W'(1);
                        if (state_d == ST_LOCK) begin
                            err_cnt_d = '0;
                            wcnt_d    = '0;
                            werr_d    = '0;
                        end
                    end
                end
                ST_LOCK: begin
                    gen_adv   = 1'b1;
                    exp_bit_d = exp_w;
                    wcnt_d    = wcnt_q + WC_W'(1);
                    if (mismatch) begin
                        bit_err_d = 1'b1;
                        werr_d    = werr_q + EC_W'(1);
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    end
                    // Losing lock wins over closing the window on the same bit.
                    if (state_d == ST_HUNT) begin
                        lock_lost_d = 1'b1;
                        hcnt_d      = '0;
                    end else if (wcnt_q == WC_LAST) begin
                        wcnt_d = '0;
                        werr_d = '0;
                    end
                end
                default: hcnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q        <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            wcnt_q      <= '0;
            werr_q      <= '0;
            err_cnt_q   <= '0;
            exp_bit_q   <= 1'b0;
            bit_err_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            wcnt_q      <= wcnt_d;
            werr_q      <= werr_d;
            err_cnt_q   <= err_cnt_d;
            exp_bit_q   <= exp_bit_d;
            bit_err_q   <= bit_err_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign bus.locked    = (state_q == ST_LOCK);
    assign bus.state     = state_q;
    assign bus.exp_bit   = exp_bit_q;
    assign bus.bit_err   = bit_err_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_m_seq_sync.sv
// Scoreboard bench for m_seq_sync: directed scenarios plus randomized streams
// compared against a sequence-level reference model.
module tb_m_seq_sync;

    localparam int         W    = 3;
    localparam logic [2:0] TAPS = 3'b101;
    localparam int         VLEN = 7;
    localparam int         WLEN = 16;
    localparam int         LTHR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    m_seq_sync_if bus ();

    m_seq_sync #(
        .WIDTH      (W),
        .TAPS       (TAPS),
        .VERIFY_LEN (VLEN),
        .WIN_LEN    (WLEN),
        .LOSS_THR   (LTHR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int locked;
        int st;
        int exp_b;
        int berr;
        int lost;
        int ecnt;
    } resp_t;

    resp_t sbq[$];
    int    checks   = 0;
    int    failures = 0;

    // Transmitter: period-7 sequence from seed 101.
    bit pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int ph = 0;

    // Reference model state: 0 hunt, 1 verify, 2 lock.
    int m_st = 0;
    bit hist[$];
    bit pred[$];
    int vok = 0, wbits = 0, werrs = 0, errs = 0;
    bit m_exp = 0, m_berr = 0, m_lost = 0;

    function automatic void check(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, expv);
        end
    endfunction

    function automatic bit predict();
        bit e = 1'b0;
        for (int i = 0; i < W; i++) if (TAPS[i]) e ^= pred[W-1-i];
        return e;
    endfunction

    function automatic void model_step(bit r, bit v, bit d);
        bit e, mis, nz;
        if (r) begin
            m_st = 0; hist.delete(); pred.delete();
            vok = 0; wbits = 0; werrs = 0; errs = 0;
            m_exp = 0; m_berr = 0; m_lost = 0;
            return;
        end
        m_berr = 0;
        m_lost = 0;
        if (!v) return;
        if (m_st == 0) begin
            m_exp = 0;
            hist.push_back(d);
            if (hist.size() > W) void'(hist.pop_front());
            if (hist.size() == W) begin
                nz = 0;
                foreach (hist[i]) nz |= hist[i];
                if (nz) begin
                    m_st = 1; pred = hist; vok = 0;
                end
            end
        end else begin
            e = predict();
            void'(pred.pop_front());
            pred.push_back(e);
            m_exp = e;
            mis = (e != d);
            if (m_st == 1) begin
                if (mis) begin
                    m_berr = 1; m_st = 0; hist.delete();
                end else begin
                    vok++;
                    if (vok == VLEN) begin
                        m_st = 2; errs = 0; wbits = 0; werrs = 0;
                    end
                end
            end else begin
                wbits++;
                if (mis) begin
                    m_berr = 1;
                    if (errs < 65535) errs++;
                    werrs++;
                end
                if (werrs == LTHR) begin
                    m_st = 0; m_lost = 1; hist.delete();
                end else if (wbits == WLEN) begin
                    wbits = 0; werrs = 0;
                end
            end
        end
    endfunction

    task automatic drive(input bit r, input bit v, input bit d);
        resp_t x;
        @(negedge clk);
        rst = r;
        bus.din_valid = v;
        bus.din = d;
        model_step(r, v, d);
        x.locked = (m_st == 2);
        x.st     = m_st;
        x.exp_b  = m_exp;
        x.berr   = m_berr;
        x.lost   = m_lost;
        x.ecnt   = errs;
        sbq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic send_tx(input bit inv);
        bit b;
        b = pat[ph] ^ inv;
        ph = (ph + 1) % 7;
        drive(1'b0, 1'b1, b);
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send_tx(1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0);
        ph = 0;
    endtask

    // Monitor: every cycle the DUT presents a response, compare with the queue head.
    initial begin
        resp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("mon_locked",    int'(bus.locked),    e.locked);
                check("mon_state",     int'(bus.state),     e.st);
                check("mon_exp_bit",   int'(bus.exp_bit),   e.exp_b);
                check("mon_bit_err",   int'(bus.bit_err),   e.berr);
                check("mon_lock_lost", int'(bus.lock_lost), e.lost);
                check("mon_err_cnt",   int'(bus.err_cnt),   e.ecnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        do_reset();
        do_reset();

        // 1: clean stream locks after bit 10
        send_clean(3);
        check("t1_verify_after_3", int'(bus.state), 1);
        send_clean(6);
        check("t1_not_locked_9", int'(bus.locked), 0);
        send_clean(1);
        check("t1_locked_10", int'(bus.locked), 1);
        send_clean(20);
        check("t1_err_cnt", int'(bus.err_cnt), 0);

        // 2: error in VERIFY drops to HUNT, relock 10 bits later
        do_reset();
        send_clean(5);
        send_tx(1'b1);
        check("t2_bit_err", int'(bus.bit_err), 1);
        check("t2_hunt", int'(bus.state), 0);
        send_clean(9);
        check("t2_not_yet", int'(bus.locked), 0);
        send_clean(1);
        check("t2_relock", int'(bus.locked), 1);

        // 3: two errors in one window, then one per window, lock kept
        for (int i = 0; i < WLEN; i++) send_tx(i == 2 || i == 9);
        check("t3_err_cnt2", int'(bus.err_cnt), 2);
        check("t3_locked", int'(bus.locked), 1);
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < WLEN; i++) send_tx(i == 5);
        check("t3_err_cnt5", int'(bus.err_cnt), 5);
        check("t3_still_locked", int'(bus.locked), 1);

        // 4: three errors in one window lose lock
        do_reset();
        send_clean(10);
        check("t4_locked", int'(bus.locked), 1);
        for (int i = 0; i < 7; i++) send_tx(i == 1 || i == 4 || i == 6);
        check("t4_lock_lost", int'(bus.lock_lost), 1);
        check("t4_unlocked", int'(bus.locked), 0);
        check("t4_hunt", int'(bus.state), 0);
        check("t4_err_cnt", int'(bus.err_cnt), 3);
        drive(1'b0, 1'b0, 1'b1);
        check("t4_pulse_end", int'(bus.lock_lost), 0);

        // 5: all-zero input never seeds
        do_reset();
        for (int i = 0; i < 50; i++) drive(1'b0, 1'b1, 1'b0);
        check("t5_hunt", int'(bus.state), 0);
        check("t5_unlocked", int'(bus.locked), 0);
        ph = 3;
        send_clean(9);
        check("t5_not_yet", int'(bus.locked), 0);
        send_clean(1);
        check("t5_locked", int'(bus.locked), 1);

        // 6: half-rate valid, then reset while locked
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            if (c % 2 == 1) send_tx(1'b0);
            else drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            if (c == 18) check("t6_not_locked_18", int'(bus.locked), 0);
            if (c == 19) check("t6_locked_19", int'(bus.locked), 1);
        end
        check("t6_locked_20", int'(bus.locked), 1);
        do_reset();
        check("t6_rst_state", int'(bus.state), 0);
        check("t6_rst_locked", int'(bus.locked), 0);
        check("t6_rst_err_cnt", int'(bus.err_cnt), 0);
        check("t6_rst_exp_bit", int'(bus.exp_bit), 0);

        // Randomized: gappy valid, sparse and dense error rates, rare resets
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 299) == 0) drive(1'b1, 1'b0, 1'b0);
            else if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            else send_tx($urandom_range(0, (i < 1200) ? 40 : 7) == 0);
        end
        for (int i = 0; i < 300; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        send_clean(40);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        check("drain_queue_empty", sbq.size(), 0);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
